// File: rtl/fault_capture_ctrl.sv
`default_nettype none
// fault_capture_ctrl: NCH-channel post-fault sample counter with delayed done pulse, capture gating and
// first-fault arbitration. Optional FAULT_TSTAMP_EN adds a per-channel fault acceptance timestamp. Rev 1.0
module fault_capture_ctrl #(
  parameter int NCH        = 4,
  parameter int CW         = 32,
  parameter int DONE_DLY   = 3,
  parameter int AUTO_REARM = 0,
  localparam int IW = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              usr_rst,
  input  logic              trig,
  input  logic [NCH-1:0]    fault_trig,
  input  logic [NCH-1:0]    chan_mask,
  input  logic [NCH*CW-1:0] ref_cnt,
  output logic [NCH*CW-1:0] cnt_out,
  output logic [NCH-1:0]    done_pulse,
  output logic [NCH-1:0]    capture_en,
  output logic [NCH-1:0]    fault_latched,
  output logic              first_valid,
  output logic [IW-1:0]     first_id,
  output logic [NCH*CW-1:0] fault_ts
);
  localparam int DW = $clog2(DONE_DLY + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, COUNT = 2'd1, HOLD = 2'd2} state_t;

  state_t                 state [NCH];
  logic [DW-1:0]          dly   [NCH];
  logic [NCH-1:0]         accept;
  logic [NCH-1:0]         match;
  logic [NCH-1:0][CW-1:0] cnt_nxt;
  logic [IW-1:0]          low_id;

  // Descending scan leaves the lowest accepting channel in low_id.
  always_comb begin
    low_id = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      accept[i]  = (state[i] == IDLE) && fault_trig[i] && chan_mask[i];
      match[i]   = (state[i] == COUNT) && (cnt_out[i*CW +: CW] >= ref_cnt[i*CW +: CW]);
      cnt_nxt[i] = cnt_out[i*CW +: CW] + CW'(trig && !match[i]);
      if (accept[i]) low_id = IW'(i);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NCH; i++) begin
        state[i] <= IDLE;
        dly[i]   <= '0;
      end
      cnt_out       <= '0;
      done_pulse    <= '0;
      capture_en    <= '1;
      fault_latched <= '0;
      first_valid   <= 1'b0;
      first_id      <= '0;
    end else if (usr_rst) begin
      for (int i = 0; i < NCH; i++) begin
        state[i] <= IDLE;
        dly[i]   <= '0;
      end
      cnt_out       <= '0;
      done_pulse    <= '0;
      capture_en    <= '1;
      fault_latched <= '0;
      first_valid   <= 1'b0;
      first_id      <= '0;
    end else begin
      if (!first_valid && (accept != '0)) begin
        first_valid <= 1'b1;
        first_id    <= low_id;
      end
      for (int i = 0; i < NCH; i++) begin
        done_pulse[i] <= 1'b0;
        case (state[i])
          IDLE: begin
            capture_en[i] <= 1'b1;
            if (accept[i]) begin
              state[i]         <= COUNT;
              fault_latched[i] <= 1'b1;
            end
          end
          COUNT: begin
            // The first edge that sees match counts as one of the DONE_DLY edges.
            if (match[i]) begin
              state[i] <= HOLD;
              if (DONE_DLY == 1) done_pulse[i] <= 1'b1;
              else               dly[i]        <= DW'(DONE_DLY - 1);
            end else begin
              cnt_out[i*CW +: CW] <= cnt_nxt[i];
            end
          end
          HOLD: begin
            if (dly[i] == DW'(1)) done_pulse[i] <= 1'b1;
            if (dly[i] != '0)     dly[i]        <= dly[i] - DW'(1);
            if (done_pulse[i]) begin
              capture_en[i] <= 1'b0;
              if (AUTO_REARM != 0) begin
                state[i]            <= IDLE;
                cnt_out[i*CW +: CW] <= '0;
              end
            end
          end
          default: state[i] <= IDLE;
        endcase
      end
    end
  end

`ifdef FAULT_TSTAMP_EN
  logic [CW-1:0] ts;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ts       <= '0;
      fault_ts <= '0;
    end else if (usr_rst) begin
      ts       <= '0;
      fault_ts <= '0;
    end else begin
      ts <= ts + CW'(1);
      for (int i = 0; i < NCH; i++)
        if (accept[i]) fault_ts[i*CW +: CW] <= ts;
    end
  end
`else
  assign fault_ts = '0;
`endif

endmodule
`default_nettype wire
